// File: rtl/run_controller.sv
// run_controller: execution sequencer for the 8-bit model CPU.
// Converts the front-panel NEXT / RUN / SPEEDRUN controls into single-cycle step pulses that
// advance the CPU by one instruction, and stops stepping once the HALT opcode is reported.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   NEXT        single-step push button (asynchronous, rising edge used)
//   RUN         run switch (asynchronous level)
//   SPEEDRUN    fast-run switch (asynchronous level), overrides RUN
//   halt        current opcode is HALT (synchronous)
//   step        registered one-cycle pulse, CPU advances one instruction
//   state       00 idle, 01 run, 10 fast, 11 halted
//   step_count  steps issued since reset, saturating at 16'hFFFF
module run_controller #(
  parameter int unsigned RUN_DIV  = 32'd50_000_000,
  parameter int unsigned FAST_DIV = 32'd50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NEXT,
  input  logic        RUN,
  input  logic        SPEEDRUN,
  input  logic        halt,
  output logic        step,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StFast   = 2'b10,
    StHalted = 2'b11
  } state_e;

  state_e      state_q;
  logic        step_q;
  logic [15:0] step_count_q;
  logic [31:0] div_q;

  logic next_meta_q, next_sync_q, next_prev_q;
  logic run_meta_q, run_sync_q;
  logic fast_meta_q, fast_sync_q;

  logic        next_rise;
  logic        switches_off;
  logic [31:0] div_last;
  logic [15:0] count_inc;

  // Two-flop synchronizers; NEXT keeps one extra stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_meta_q <= 1'b0;
      next_sync_q <= 1'b0;
      next_prev_q <= 1'b0;
      run_meta_q  <= 1'b0;
      run_sync_q  <= 1'b0;
      fast_meta_q <= 1'b0;
      fast_sync_q <= 1'b0;
    end else begin
      next_meta_q <= NEXT;
      next_sync_q <= next_meta_q;
      next_prev_q <= next_sync_q;
      run_meta_q  <= RUN;
      run_sync_q  <= run_meta_q;
      fast_meta_q <= SPEEDRUN;
      fast_sync_q <= fast_meta_q;
    end
  end

  always_comb begin
    next_rise    = next_sync_q & ~next_prev_q;
    switches_off = ~run_sync_q & ~fast_sync_q;
    div_last     = (state_q == StFast) ? 32'(FAST_DIV - 1) : 32'(RUN_DIV - 1);
    count_inc    = (step_count_q == 16'hFFFF) ? step_count_q : step_count_q + 16'd1;
  end

  // step and step_count are registered together so step_count rises with each pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      step_q       <= 1'b0;
      step_count_q <= 16'd0;
      div_q        <= 32'd0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fast_sync_q) begin
            state_q <= StFast;
            div_q   <= 32'd0;
          end else if (run_sync_q) begin
            state_q <= StRun;
            div_q   <= 32'd0;
          end else if (next_rise) begin
            if (halt) begin
              state_q <= StHalted;
            end else begin
              step_q       <= 1'b1;
              step_count_q <= count_inc;
            end
          end
        end
        StRun, StFast: begin
          if (switches_off) begin
            state_q <= StIdle;
            div_q   <= 32'd0;
          end else if (fast_sync_q != (state_q == StFast)) begin
            // Mode switch restarts the period; no step on the switching edge.
            state_q <= fast_sync_q ? StFast : StRun;
            div_q   <= 32'd0;
          end else if (div_q == div_last) begin
            div_q <= 32'd0;
            if (halt) begin
              state_q <= StHalted;
            end else begin
              step_q       <= 1'b1;
              step_count_q <= count_inc;
            end
          end else begin
            div_q <= div_q + 32'd1;
          end
        end
        StHalted: begin
          if (!halt && switches_off) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign step       = step_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed scenarios plus randomized phases, every cycle compared
// against a behavioural model that counts cycles since mode entry and steps on multiples of
// the period.
module tb_run_controller;

  localparam int unsigned RunDiv  = 8;
  localparam int unsigned FastDiv = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        next_in = 1'b0;
  logic        run_in = 1'b0;
  logic        fast_in = 1'b0;
  logic        halt = 1'b0;
  logic        step;
  logic [1:0]  state;
  logic [15:0] step_count;

  run_controller #(
    .RUN_DIV  (RunDiv),
    .FAST_DIV (FastDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .NEXT       (next_in),
    .RUN        (run_in),
    .SPEEDRUN   (fast_in),
    .halt       (halt),
    .step       (step),
    .state      (state),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 fast, 3 halted.
  int m_mode, m_since, m_cnt;
  bit m_step;
  bit n1, n2, n3, r1, r2, f1, f2;

  task automatic model_reset();
    m_mode = 0; m_since = 0; m_cnt = 0; m_step = 0;
    n1 = 0; n2 = 0; n3 = 0; r1 = 0; r2 = 0; f1 = 0; f2 = 0;
  endtask

  task automatic model_edge();
    bit rl, fl, ne;
    int tgt, period;
    rl = r2; fl = f2; ne = n2 & ~n3;
    m_step = 0;
    case (m_mode)
      0: begin
        if (fl) begin m_mode = 2; m_since = 0; end
        else if (rl) begin m_mode = 1; m_since = 0; end
        else if (ne) begin
          if (halt) m_mode = 3;
          else m_step = 1;
        end
      end
      1, 2: begin
        tgt = fl ? 2 : (rl ? 1 : 0);
        if (tgt != m_mode) begin
          m_mode = tgt; m_since = 0;
        end else begin
          m_since++;
          period = (m_mode == 2) ? FastDiv : RunDiv;
          if (m_since % period == 0) begin
            if (halt) m_mode = 3;
            else m_step = 1;
          end
        end
      end
      default: if (!halt && !rl && !fl) m_mode = 0;
    endcase
    if (m_step && m_cnt < 65535) m_cnt++;
    n3 = n2; n2 = n1; n1 = next_in;
    r2 = r1; r1 = run_in;
    f2 = f1; f1 = fast_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("step", {31'd0, step}, {31'd0, m_step});
    check("state", {30'd0, state}, m_mode);
    check("step_count", {16'd0, step_count}, m_cnt);
    if (step === 1'b1) pulses++;
  endtask

  // Called just after a rising edge; reset lands mid-cycle.
  task automatic apply_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_count", {16'd0, step_count}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, op, n;
    model_reset();
    #2;
    check("init_step", {31'd0, step}, 32'd0);
    check("init_state", {30'd0, state}, 32'd0);
    check("init_count", {16'd0, step_count}, 32'd0);
    #10 rst = 1'b0;

    // Single step: one pulse three edges after NEXT is first sampled, even if held.
    repeat (3) cyc();
    pulses = 0;
    lat = 0;
    next_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (step === 1'b1) begin lat = i + 1; break; end
    end
    check("next_latency", lat, 3);
    repeat (100) cyc();
    check("next_hold_pulses", pulses, 1);
    next_in = 1'b0;

    // RUN: five pulses in the 40 cycles after entry, none after release.
    repeat (3) cyc();
    pulses = 0;
    run_in = 1'b1;
    repeat (43) cyc();
    check("run_pulses", pulses, 5);
    check("run_state", {30'd0, state}, 32'd1);
    run_in = 1'b0;
    pulses = 0;
    repeat (20) cyc();
    check("run_stop_pulses", pulses, 0);
    check("run_stop_state", {30'd0, state}, 32'd0);

    // SPEEDRUN override and release.
    run_in = 1'b1;
    repeat (12) cyc();
    fast_in = 1'b1;
    repeat (3) cyc();
    pulses = 0;
    repeat (12) cyc();
    check("fast_pulses", pulses, 4);
    check("fast_state", {30'd0, state}, 32'd2);
    fast_in = 1'b0;
    repeat (3) cyc();
    pulses = 0;
    repeat (16) cyc();
    check("back_to_run_pulses", pulses, 2);
    check("back_to_run_state", {30'd0, state}, 32'd1);

    // Halt raised one cycle before a due fast step.
    fast_in = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (step === 1'b1) break;
    end
    cyc();
    halt = 1'b1;
    pulses = 0;
    repeat (2) cyc();
    check("halt_state", {30'd0, state}, 32'd3);
    repeat (3) begin
      next_in = 1'b1; repeat (2) cyc();
      next_in = 1'b0; repeat (2) cyc();
    end
    check("halt_pulses", pulses, 0);
    halt = 1'b0; run_in = 1'b0; fast_in = 1'b0;
    repeat (4) cyc();
    check("unhalt_state", {30'd0, state}, 32'd0);

    // Saturation: preload the counter near the top, then keep stepping.
    fast_in = 1'b1;
    repeat (3) cyc();
    force dut.step_count_q = 16'hFFFD;
    #1 release dut.step_count_q;
    m_cnt = 16'hFFFD;
    repeat (15) cyc();
    check("sat_count", {16'd0, step_count}, 32'h0000FFFF);
    fast_in = 1'b0;
    repeat (4) cyc();

    // Randomized phases.
    for (int p = 0; p < 40; p++) begin
      op = $urandom_range(0, 4);
      n  = $urandom_range(4, 40);
      case (op)
        0: begin next_in = 0; run_in = 1; fast_in = 0; repeat (n) cyc(); end
        1: begin next_in = 0; fast_in = 1; run_in = 1'($urandom_range(0, 1)); repeat (n) cyc(); end
        2: begin
          run_in = 0; fast_in = 0;
          halt = ($urandom_range(0, 3) == 0);
          repeat (4) cyc();
          next_in = 1; repeat ($urandom_range(1, 6)) cyc();
          next_in = 0; repeat ($urandom_range(1, 6)) cyc();
          halt = 0;
        end
        3: begin halt = 1; repeat ($urandom_range(1, 8)) cyc(); halt = 0; repeat (n) cyc(); end
        default: begin next_in = 0; run_in = 0; fast_in = 0; repeat (n) cyc(); end
      endcase
    end

    // Reset in the middle of a RUN period.
    next_in = 0; halt = 0; fast_in = 0; run_in = 0;
    repeat (6) cyc();
    run_in = 1;
    repeat (13) cyc();
    apply_reset();
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
